// File: rtl/skolem_inv_checker_pkg.sv
// Shared types and helpers for the Skolem invertibility-condition checker.
package skolem_chk_pkg;

  localparam int DEFAULT_W = 4;

  typedef enum logic [2:0] {IDLE, APPLY, DIV_IC, DIV_X, CHECK, DONE} state_e;

  function automatic logic [31:0] all_ones(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/skolem_inv_checker_if.sv
// Checker <-> Skolem block / host bundle: sweep operands out, Skolem x in, status and results out.
interface skolem_inv_checker_if #(
  parameter int W     = skolem_chk_pkg::DEFAULT_W,
  parameter int CNT_W = 2*W+1
);
  logic             start;
  logic [W-1:0]     sk_s;
  logic [W-1:0]     sk_t;
  logic [W-1:0]     sk_x;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] ic_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [3*W-1:0]   first_fail;

  modport master (
    input  start, sk_x,
    output sk_s, sk_t, busy, done, pass, ic_cnt, fail_cnt, first_fail
  );

  modport slave (
    output start, sk_x,
    input  sk_s, sk_t, busy, done, pass, ic_cnt, fail_cnt, first_fail
  );
endinterface

// File: rtl/skolem_inv_checker_bv_udiv_seq.sv
// Restoring unsigned divider, one quotient bit per cycle; divisor 0 yields q=all ones, r=dividend.
module bv_udiv_seq #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         div_done
);
  localparam int CW = $clog2(W+1);

  logic          act_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  a_q, q_q, r_q, d_q;

  logic [W-1:0]  a_src, q_src, r_src, d_src, r_nxt;
  logic [W:0]    trial;
  logic          qbit;

  // The start cycle already retires the first quotient bit, so q lands W cycles after start.
  always_comb begin
    a_src = start ? dividend : a_q;
    q_src = start ? '0 : q_q;
    r_src = start ? '0 : r_q;
    d_src = start ? divisor : d_q;
    trial = {r_src, a_src[W-1]};
    qbit  = (trial >= {1'b0, d_src});
    r_nxt = qbit ? W'(trial - {1'b0, d_src}) : trial[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= 1'b0;
      cnt_q <= '0;
      a_q   <= '0;
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
    end else if (start || (act_q && cnt_q != '0)) begin
      act_q <= 1'b1;
      cnt_q <= start ? CW'(W-1) : cnt_q - 1'b1;
      a_q   <= a_src << 1;
      q_q   <= W'({q_src, qbit});
      r_q   <= r_nxt;
      d_q   <= d_src;
    end else if (act_q) begin
      act_q <= 1'b0;
    end
  end

  assign div_done = act_q && (cnt_q == '0);
  assign q        = q_q;
  assign r        = r_q;

endmodule

// File: rtl/skolem_inv_checker.sv
// Exhaustive (s,t) sweep checking (x udiv s) >=u t wherever (ALL_ONES udiv s) >=u t holds.
// Define SKOLEM_CHK_STOP_ON_FAIL_EN to end the sweep at the first failing pair.
module skolem_inv_checker
  import skolem_chk_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int CNT_W = 2*W+1
) (
  input  logic                 clk,
  input  logic                 rst,
  skolem_inv_checker_if.master bus
);
  localparam logic [W-1:0] ALL_ONES = W'(all_ones(W));
  localparam int           W2       = 2*W;

  state_e           state_q;
  logic [W2-1:0]    idx_q;
  logic [W-1:0]     x_q;
  logic             ic_q, lt_q;
  logic             busy_q, done_q, pass_q;
  logic [CNT_W-1:0] ic_cnt_q, fail_cnt_q;
  logic [3*W-1:0]   first_fail_q;

  logic [W-1:0]     s_cur, t_cur, div_dividend, div_q, div_r;
  logic             div_start, div_done, fail_inc, last;
  logic [CNT_W-1:0] ic_cnt_d, fail_cnt_d;

  assign s_cur = idx_q[W2-1:W];
  assign t_cur = idx_q[W-1:0];

  // One divider serves both phases: IC quotient first, then the Skolem quotient.
  assign div_start    = (state_q == APPLY) || (state_q == DIV_IC && div_done);
  assign div_dividend = (state_q == APPLY) ? ALL_ONES : x_q;

  bv_udiv_seq #(.W(W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (s_cur),
    .q        (div_q),
    .r        (div_r),
    .div_done (div_done)
  );

  assign fail_inc   = ic_q && lt_q;
  assign ic_cnt_d   = ic_cnt_q + CNT_W'(ic_q);
  assign fail_cnt_d = fail_cnt_q + CNT_W'(fail_inc);
`ifdef SKOLEM_CHK_STOP_ON_FAIL_EN
  assign last = (&idx_q) || fail_inc;
`else
  assign last = &idx_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      x_q          <= '0;
      ic_q         <= 1'b0;
      lt_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      ic_cnt_q     <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (bus.start) begin
          state_q      <= APPLY;
          idx_q        <= '0;
          ic_cnt_q     <= '0;
          fail_cnt_q   <= '0;
          first_fail_q <= '0;
          busy_q       <= 1'b1;
          done_q       <= 1'b0;
          pass_q       <= 1'b0;
        end
        APPLY: begin
          x_q     <= bus.sk_x;
          state_q <= DIV_IC;
        end
        DIV_IC: if (div_done) begin
          ic_q    <= (div_q >= t_cur);
          state_q <= DIV_X;
        end
        DIV_X: if (div_done) begin
          lt_q    <= (div_q < t_cur);
          state_q <= CHECK;
        end
        CHECK: begin
          ic_cnt_q   <= ic_cnt_d;
          fail_cnt_q <= fail_cnt_d;
          if (fail_inc && fail_cnt_q == '0)
            first_fail_q <= {s_cur, t_cur, x_q};
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_cnt_d == '0);
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= APPLY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Divider sanity: q*s + r reconstructs the dividend with r < s.
  always_ff @(posedge clk) begin
    if (!rst && div_done && s_cur != '0)
      assert ((W2'(div_q) * W2'(s_cur) + W2'(div_r)
               == W2'((state_q == DIV_IC) ? ALL_ONES : x_q)) && (div_r < s_cur));
  end

  assign bus.sk_s       = s_cur;
  assign bus.sk_t       = t_cur;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.ic_cnt     = ic_cnt_q;
  assign bus.fail_cnt   = fail_cnt_q;
  assign bus.first_fail = first_fail_q;

endmodule

// File: tb/tb_skolem_inv_checker.sv
// Directed bench for skolem_inv_checker: stub Skolem outputs, start/reset corner cases.
module tb_skolem_inv_checker;
  localparam int W     = 4;
  localparam int CNT_W = 2*W+1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc;

  skolem_inv_checker_if #(.W(W), .CNT_W(CNT_W)) bus ();

  skolem_inv_checker #(.W(W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // 0: x=F, 1: x=0, 2: x=s*t (a valid Skolem function for this IC)
  always_comb begin
    case (mode)
      0:       bus.sk_x = 4'hF;
      1:       bus.sk_x = 4'h0;
      default: bus.sk_x = W'(bus.sk_s * bus.sk_t);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accepting edge, i.e. in cycle 1 of the sweep.
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int c);
    c = from;
    while (!bus.done && c < 4000) begin
      tick();
      c++;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"},       32'(bus.busy),       32'd0);
    chk({tag, ".done"},       32'(bus.done),       32'd0);
    chk({tag, ".pass"},       32'(bus.pass),       32'd0);
    chk({tag, ".ic_cnt"},     32'(bus.ic_cnt),     32'd0);
    chk({tag, ".fail_cnt"},   32'(bus.fail_cnt),   32'd0);
    chk({tag, ".first_fail"}, 32'(bus.first_fail), 32'd0);
    chk({tag, ".sk_s"},       32'(bus.sk_s),       32'd0);
    chk({tag, ".sk_t"},       32'(bus.sk_t),       32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    repeat (3) tick();
    chk_zero("rst_held");
    rst = 1'b0;
    tick();
    chk_zero("rst_idle");

    // Sweep 1: x = all ones never fails
    mode = 0;
    pulse_start();
    chk("s1.busy", 32'(bus.busy), 32'd1);
    chk("s1.sk_s0", 32'(bus.sk_s), 32'd0);
    chk("s1.sk_t0", 32'(bus.sk_t), 32'd0);
    repeat (10) tick();
    chk("s1.sk_s1", 32'(bus.sk_s), 32'd0);
    chk("s1.sk_t1", 32'(bus.sk_t), 32'd1);
    wait_done(11, cyc);
    chk("s1.done_cycle", 32'(cyc), 32'd2561);
    chk("s1.busy_end", 32'(bus.busy), 32'd0);
    chk("s1.pass", 32'(bus.pass), 32'd1);
    chk("s1.ic_cnt", 32'(bus.ic_cnt), 32'd76);
    chk("s1.fail_cnt", 32'(bus.fail_cnt), 32'd0);
    chk("s1.first_fail", 32'(bus.first_fail), 32'd0);

    // Sweep 2: x = 0, restarted from DONE, extra start while busy
    mode = 1;
    pulse_start();
    chk("s2.done_clr", 32'(bus.done), 32'd0);
    chk("s2.busy", 32'(bus.busy), 32'd1);
    chk("s2.ic_clr", 32'(bus.ic_cnt), 32'd0);
    repeat (99) tick();
    pulse_start();
    chk("s2.busy_after_restart", 32'(bus.busy), 32'd1);
    wait_done(101, cyc);
`ifdef SKOLEM_CHK_STOP_ON_FAIL_EN
    chk("s2.done_cycle", 32'(cyc), 32'd181);
    chk("s2.ic_cnt", 32'(bus.ic_cnt), 32'd18);
    chk("s2.fail_cnt", 32'(bus.fail_cnt), 32'd1);
`else
    chk("s2.done_cycle", 32'(cyc), 32'd2561);
    chk("s2.ic_cnt", 32'(bus.ic_cnt), 32'd76);
    chk("s2.fail_cnt", 32'(bus.fail_cnt), 32'd45);
`endif
    chk("s2.pass", 32'(bus.pass), 32'd0);
    chk("s2.first_fail", 32'(bus.first_fail), 32'h110);

    // Sweep 3: x = s*t
    mode = 2;
    pulse_start();
    wait_done(1, cyc);
    chk("s3.done_cycle", 32'(cyc), 32'd2561);
    chk("s3.pass", 32'(bus.pass), 32'd1);
    chk("s3.ic_cnt", 32'(bus.ic_cnt), 32'd76);
    chk("s3.fail_cnt", 32'(bus.fail_cnt), 32'd0);

    // Reset mid-sweep, then rerun sweep 1
    mode = 0;
    pulse_start();
    repeat (499) tick();
    chk("s4.ic_midsweep", 32'(bus.ic_cnt != '0), 32'd1);
    rst = 1'b1;
    tick();
    chk_zero("s4.rst");
    rst = 1'b0;
    tick();
    pulse_start();
    wait_done(1, cyc);
    chk("s4.done_cycle", 32'(cyc), 32'd2561);
    chk("s4.pass", 32'(bus.pass), 32'd1);
    chk("s4.ic_cnt", 32'(bus.ic_cnt), 32'd76);
    chk("s4.fail_cnt", 32'(bus.fail_cnt), 32'd0);
    chk("s4.first_fail", 32'(bus.first_fail), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
